// File: rtl/wb_sram_bist_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_sram_bist_if : Wishbone pipelined bus bundle for the SRAM BIST  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface wb_sram_bist_if #(
    parameter int AW = 15
) ();
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [31:0]   o_wb_data;
    logic [3:0]    o_wb_sel;
    logic          i_wb_stall;
    logic          i_wb_ack;
    logic          i_wb_err;
    logic [31:0]   i_wb_data;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );
endinterface
`default_nettype wire

// File: rtl/wb_sram_bist.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_sram_bist : write-then-readback memory test, Wishbone master    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module wb_sram_bist #(
    parameter int AW        = 15,
    parameter int LGTIMEOUT = 6
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic [AW-1:0] i_first,
    input  logic [AW-1:0] i_last,
    input  logic [31:0]   i_seed,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_fail,
    output logic          o_timeout,
    output logic [15:0]   o_err_count,
    output logic [AW-1:0] o_err_addr,
    output logic [31:0]   o_err_data,
    wb_sram_bist_if.master wb
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WREQ = 3'd1,
        S_WACK = 3'd2,
        S_GAP  = 3'd3,
        S_RREQ = 3'd4,
        S_RACK = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [AW-1:0]        r_first;
    logic [AW-1:0]        r_last;
    logic [AW-1:0]        r_addr;
    logic [31:0]          r_seed;
    logic [LGTIMEOUT-1:0] r_tmo;
    logic                 r_fail;
    logic                 r_timeout;
    logic [15:0]          r_err_count;
    logic [AW-1:0]        r_err_addr;
    logic [31:0]          r_err_data;

    logic                 w_cyc;
    logic                 w_stb;
    logic                 w_we;
    logic [15:0]          w_a16;
    logic [31:0]          w_pattern;
    logic                 w_last_word;
    logic                 w_tmo_hit;
    logic                 w_mismatch;

    assign w_a16       = 16'(r_addr);
    assign w_pattern   = r_seed ^ {~w_a16, w_a16};
    assign w_last_word = (r_addr == r_last);
    assign w_tmo_hit   = &r_tmo;
    assign w_mismatch  = (wb.i_wb_data != w_pattern);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Bus error wins over a simultaneous ack; acks outside the ACK states are ignored.
    always_comb begin
        w_next = r_state;
        w_cyc  = 1'b0;
        w_stb  = 1'b0;
        w_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start)
                    w_next = S_WREQ;
            end
            S_WREQ: begin
                w_cyc = 1'b1;
                w_stb = 1'b1;
                w_we  = 1'b1;
                if (!wb.i_wb_stall)
                    w_next = S_WACK;
            end
            S_WACK: begin
                w_cyc = 1'b1;
                w_we  = 1'b1;
                if (wb.i_wb_err)
                    w_next = S_DONE;
                else if (wb.i_wb_ack)
                    w_next = w_last_word ? S_GAP : S_WREQ;
                else if (w_tmo_hit)
                    w_next = S_DONE;
            end
            S_GAP: begin
                w_next = S_RREQ;
            end
            S_RREQ: begin
                w_cyc = 1'b1;
                w_stb = 1'b1;
                if (!wb.i_wb_stall)
                    w_next = S_RACK;
            end
            S_RACK: begin
                w_cyc = 1'b1;
                if (wb.i_wb_err)
                    w_next = S_DONE;
                else if (wb.i_wb_ack)
                    w_next = w_last_word ? S_DONE : S_RREQ;
                else if (w_tmo_hit)
                    w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_first     <= '0;
            r_last      <= '0;
            r_addr      <= '0;
            r_seed      <= '0;
            r_tmo       <= '0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_count <= '0;
            r_err_addr  <= '0;
            r_err_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_first     <= i_first;
                        r_last      <= i_last;
                        r_seed      <= i_seed;
                        r_addr      <= i_first;
                        r_tmo       <= '0;
                        r_fail      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_err_count <= '0;
                        r_err_addr  <= '0;
                        r_err_data  <= '0;
                    end
                end
                S_WREQ, S_RREQ: begin
                    if (!wb.i_wb_stall)
                        r_tmo <= '0;
                end
                S_WACK: begin
                    if (wb.i_wb_err) begin
                        r_fail <= 1'b1;
                    end else if (wb.i_wb_ack) begin
                        if (!w_last_word)
                            r_addr <= r_addr + AW'(1);
                    end else if (w_tmo_hit) begin
                        r_fail    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + LGTIMEOUT'(1);
                    end
                end
                S_GAP: begin
                    r_addr <= r_first;
                end
                S_RACK: begin
                    if (wb.i_wb_err) begin
                        r_fail <= 1'b1;
                    end else if (wb.i_wb_ack) begin
                        if (w_mismatch) begin
                            if (r_err_count != 16'hFFFF)
                                r_err_count <= r_err_count + 16'd1;
                            if (r_err_count == 16'd0) begin
                                r_err_addr <= r_addr;
                                r_err_data <= wb.i_wb_data;
                            end
                        end
                        // Mismatch history is folded into o_fail on entry to DONE.
                        if (w_last_word)
                            r_fail <= r_fail | w_mismatch | (r_err_count != 16'd0);
                        else
                            r_addr <= r_addr + AW'(1);
                    end else if (w_tmo_hit) begin
                        r_fail    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + LGTIMEOUT'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done      = (r_state == S_DONE);
    assign o_fail      = r_fail;
    assign o_timeout   = r_timeout;
    assign o_err_count = r_err_count;
    assign o_err_addr  = r_err_addr;
    assign o_err_data  = r_err_data;

    assign wb.o_wb_cyc  = w_cyc;
    assign wb.o_wb_stb  = w_stb;
    assign wb.o_wb_we   = w_we;
    assign wb.o_wb_addr = r_addr;
    assign wb.o_wb_data = w_we ? w_pattern : 32'h0;
    assign wb.o_wb_sel  = 4'hf;

endmodule
`default_nettype wire
